// File: rtl/sysctrl_master.sv
// -----------------------------------------------------------------------------
// sysctrl_master
// Initiator for the system-control byte bus. One frame at a time is taken from
// local logic: a command byte followed by 0..MAX_LEN payload bytes read from
// the tx buffer. Bytes go out on bus_strobe at a fixed spacing of GAP clocks.
// After every payload strobe the responder's reply (bus_din) is captured into
// the rx buffer on the last cycle before the next strobe slot.
//
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   req_valid/req_ready    frame handshake (ready only while idle)
//   req_cmd, req_len       command byte and payload length (clamped to MAX_LEN)
//   buf_we/addr/wdata      tx buffer write port (honoured only while idle)
//   rsp_addr, rsp_data     rx buffer read port, one cycle latency
//   busy, done             frame in progress / one-cycle end-of-frame pulse
//   frame_count            completed frames, wrapping 16-bit counter
//   bus_strobe/start/data  byte strobe, first-byte flag and byte to responder
//   bus_din                byte returned by responder
// -----------------------------------------------------------------------------
module sysctrl_master #(
    parameter int GAP     = 4,
    parameter int MAX_LEN = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_cmd,
    input  logic [3:0]  req_len,
    input  logic        buf_we,
    input  logic [2:0]  buf_addr,
    input  logic [7:0]  buf_wdata,
    input  logic [2:0]  rsp_addr,
    output logic [7:0]  rsp_data,
    output logic        busy,
    output logic        done,
    output logic [15:0] frame_count,
    output logic        bus_strobe,
    output logic        bus_start,
    output logic [7:0]  bus_data,
    input  logic [7:0]  bus_din
);

    if (GAP < 2 || GAP > 15) begin : g_gap_check
        $error("sysctrl_master: GAP must be within 2..15");
    end

    if (MAX_LEN < 2 || MAX_LEN > 8) begin : g_len_check
        $error("sysctrl_master: MAX_LEN must be within 2..8");
    end

    localparam int         AW       = $clog2(MAX_LEN);
    localparam logic [3:0] GAP_LAST = 4'(GAP - 2);
    localparam logic [3:0] LEN_MAX  = 4'(MAX_LEN);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STROBE  = 2'd1,
        GAPWAIT = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [3:0]      len_r;
    logic [3:0]      idx_r;
    logic [3:0]      cnt_r;
    logic [7:0]      tx_buf [MAX_LEN];
    logic [7:0]      rx_buf [MAX_LEN];

    logic            accept_s;
    logic            last_gap_s;
    logic            capture_s;
    logic            load_strobe_s;
    logic            load_start_s;
    logic [7:0]      load_data_s;
    logic [3:0]      len_clamp_s;
    logic [AW-1:0]   rx_idx_s;
    logic            tx_wr_ok_s;
    logic            rsp_rd_ok_s;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus the byte that the next strobe cycle will carry.
    // Strobe outputs are registered, so they are prepared one cycle early.
    always_comb begin
        state_next    = state;
        load_strobe_s = 1'b0;
        load_start_s  = 1'b0;
        load_data_s   = 8'h00;
        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    state_next    = STROBE;
                    load_strobe_s = 1'b1;
                    load_start_s  = 1'b1;
                    load_data_s   = req_cmd;
                end else begin
                    state_next = IDLE;
                end
            end
            STROBE: begin
                state_next = GAPWAIT;
            end
            GAPWAIT: begin
                if (cnt_r == GAP_LAST) begin
                    // idx_r counts strobes already sent; payload k uses tx_buf[k-1]
                    if (idx_r < len_r) begin
                        state_next    = STROBE;
                        load_strobe_s = 1'b1;
                        load_data_s   = tx_buf[idx_r[AW-1:0]];
                    end else begin
                        state_next = DONE;
                    end
                end else begin
                    state_next = GAPWAIT;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Handshake, capture and buffer-port qualifiers.
    always_comb begin
        accept_s    = (state == IDLE) && req_valid && req_ready;
        last_gap_s  = (state == GAPWAIT) && (cnt_r == GAP_LAST);
        // the command strobe (idx 0) has no reply to capture
        capture_s   = last_gap_s && (idx_r != 4'd0);
        rx_idx_s    = AW'(idx_r - 4'd1);
        len_clamp_s = (req_len > LEN_MAX) ? LEN_MAX : req_len;
        tx_wr_ok_s  = (state == IDLE) && buf_we && ({1'b0, buf_addr} < LEN_MAX);
        rsp_rd_ok_s = ({1'b0, rsp_addr} < LEN_MAX);
    end

    // Frame sequencing: latched length, strobe index and gap counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_r <= 4'd0;
            idx_r <= 4'd0;
            cnt_r <= 4'd0;
        end else begin
            if (accept_s) begin
                len_r <= len_clamp_s;
                idx_r <= 4'd0;
            end else if (last_gap_s && (state_next == STROBE)) begin
                idx_r <= idx_r + 4'd1;
            end
            if (state == GAPWAIT) begin
                cnt_r <= cnt_r + 4'd1;
            end else begin
                cnt_r <= 4'd0;
            end
        end
    end

    // tx buffer writes (idle only) and rx captures of responder bytes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                tx_buf[i] <= 8'h00;
                rx_buf[i] <= 8'h00;
            end
        end else begin
            if (tx_wr_ok_s) begin
                tx_buf[buf_addr[AW-1:0]] <= buf_wdata;
            end
            if (capture_s) begin
                rx_buf[rx_idx_s] <= bus_din;
            end
        end
    end

    // Registered outputs, all decoded from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_ready   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            frame_count <= 16'h0000;
            bus_strobe  <= 1'b0;
            bus_start   <= 1'b0;
            bus_data    <= 8'h00;
            rsp_data    <= 8'h00;
        end else begin
            req_ready  <= (state_next == IDLE);
            busy       <= (state_next == STROBE) || (state_next == GAPWAIT);
            done       <= (state_next == DONE);
            bus_strobe <= load_strobe_s;
            bus_start  <= load_start_s;
            if (load_strobe_s) begin
                bus_data <= load_data_s;
            end
            if (state_next == DONE) begin
                frame_count <= frame_count + 16'd1;
            end
            rsp_data <= rsp_rd_ok_s ? rx_buf[rsp_addr[AW-1:0]] : 8'h00;
        end
    end

endmodule

// File: tb/tb_sysctrl_master.sv
module tb_sysctrl_master;

    localparam int GAP = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_cmd;
    logic [3:0]  req_len;
    logic        buf_we;
    logic [2:0]  buf_addr;
    logic [7:0]  buf_wdata;
    logic [2:0]  rsp_addr;
    logic [7:0]  rsp_data;
    logic        busy;
    logic        done;
    logic [15:0] frame_count;
    logic        bus_strobe;
    logic        bus_start;
    logic [7:0]  bus_data;
    logic [7:0]  bus_din = 8'h00;

    sysctrl_master #(.GAP(GAP), .MAX_LEN(8)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_cmd(req_cmd), .req_len(req_len),
        .buf_we(buf_we), .buf_addr(buf_addr), .buf_wdata(buf_wdata),
        .rsp_addr(rsp_addr), .rsp_data(rsp_data),
        .busy(busy), .done(done), .frame_count(frame_count),
        .bus_strobe(bus_strobe), .bus_start(bus_start), .bus_data(bus_data),
        .bus_din(bus_din)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic       start;
        logic [7:0] data;
    } strb_t;

    typedef struct {
        logic [7:0]  cmd;
        logic [3:0]  len;
        logic [63:0] pay;
        logic [63:0] rsp;
        int          nstr;
        int          done_t;
    } vec_t;

    strb_t      exp_q[$];
    int         done_q[$];
    int         total = 0;
    int         bad = 0;
    int         str_cnt = 0;
    int         rk = 0;
    int         fc_model = 0;
    logic [7:0] tx_model [8];
    logic [7:0] rx_model [8];
    logic [7:0] rsp_pat  [8];
    vec_t       vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Bus monitor, scoreboard pop and responder model.
    always @(negedge clk) begin
        strb_t e;
        if (!reset) begin
            if (bus_strobe) begin
                str_cnt++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_strobe: got data %0h at cycle %0d, expected none", bus_data, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("strobe_cycle", cyc, e.cyc);
                    chk("strobe_start", {31'd0, bus_start}, {31'd0, e.start});
                    chk("strobe_data", {24'd0, bus_data}, {24'd0, e.data});
                end
                if (bus_start) rk = 0;
                else rk = rk + 1;
                bus_din = (rk > 0 && rk <= 8) ? rsp_pat[rk-1] : 8'hEE;
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got pulse at cycle %0d, expected none", cyc);
                end else begin
                    chk("done_cycle", cyc, done_q.pop_front());
                end
            end
            if (busy) chk("busy_ready_excl", {31'd0, req_ready}, 32'd0);
        end
    end

    task automatic push_frame(input int t, input logic [7:0] cmd, input int leff, input int done_off);
        exp_q.push_back('{t + 1, 1'b1, cmd});
        for (int j = 1; j <= leff; j++) exp_q.push_back('{t + 1 + j * GAP, 1'b0, tx_model[j-1]});
        done_q.push_back(t + done_off);
    endtask

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: got req_ready=0 after 100 cycles, expected 1");
        end
    endtask

    task automatic wait_done();
        int n = 0;
        @(negedge clk);
        while (!done && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got no done within 300 cycles, expected a pulse");
        end
    endtask

    task automatic wr_tx(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        buf_we = 1'b1;
        buf_addr = a;
        buf_wdata = d;
        @(negedge clk);
        buf_we = 1'b0;
        tx_model[a] = d;
    endtask

    task automatic check_rx();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rsp_addr = 3'(i);
            @(posedge clk);
            #1;
            chk($sformatf("rx[%0d]", i), {24'd0, rsp_data}, {24'd0, rx_model[i]});
        end
    endtask

    task automatic run_frame(input logic [7:0] cmd, input logic [3:0] len, input int nstr, input int done_t);
        int leff;
        int t;
        int s0;
        leff = (len > 4'd8) ? 8 : int'(len);
        wait_ready();
        req_cmd = cmd;
        req_len = len;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        t = cyc - 1;
        push_frame(t, cmd, leff, done_t);
        s0 = str_cnt;
        wait_done();
        chk("strobe_count", str_cnt - s0, nstr);
        for (int k = 0; k < leff; k++) rx_model[k] = rsp_pat[k];
        fc_model++;
        chk("frame_count", {16'd0, frame_count}, fc_model);
        check_rx();
    endtask

    initial begin
        int t;
        int s0;
        reset = 1'b1;
        req_valid = 1'b0;
        req_cmd = 8'h00;
        req_len = 4'd0;
        buf_we = 1'b0;
        buf_addr = 3'd0;
        buf_wdata = 8'h00;
        rsp_addr = 3'd0;
        for (int i = 0; i < 8; i++) begin
            tx_model[i] = 8'h00;
            rx_model[i] = 8'h00;
            rsp_pat[i]  = 8'h00;
        end

        vecs[0] = '{8'h00, 4'd3,  64'h0,                  64'h0000_0000_0004_425C, 4, 17};
        vecs[1] = '{8'h01, 4'd0,  64'h0,                  64'hFFFF_FFFF_FFFF_FFFF, 1, 5};
        vecs[2] = '{8'hA5, 4'd12, 64'h8877_6655_4433_2211, 64'h0F1E_2D3C_4B5A_6978, 9, 37};
        vecs[3] = '{8'h7E, 4'd2,  64'h0000_0000_0000_BEEF, 64'h0000_0000_0000_C0DE, 3, 13};
        vecs[4] = '{8'h3C, 4'd8,  64'hF0E1_D2C3_B4A5_9687, 64'h1020_3040_5060_7080, 9, 37};

        // reset state
        #12;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_strobe", {31'd0, bus_strobe}, 32'd0);
        chk("rst_start", {31'd0, bus_start}, 32'd0);
        chk("rst_bus_data", {24'd0, bus_data}, 32'd0);
        chk("rst_frame_count", {16'd0, frame_count}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_release", {31'd0, req_ready}, 32'd1);
        check_rx();

        // back-to-back frames with req_valid held high
        wr_tx(3'd0, 8'hC3);
        rsp_pat[0] = 8'h9A;
        wait_ready();
        req_cmd = 8'h20;
        req_len = 4'd1;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        t = cyc - 1;
        s0 = str_cnt;
        push_frame(t, 8'h20, 1, 9);
        push_frame(t + 10, 8'h20, 1, 9);
        repeat (11) @(posedge clk);
        #1;
        req_valid = 1'b0;
        wait_done();
        chk("b2b_strobes", str_cnt - s0, 4);
        fc_model = fc_model + 2;
        chk("b2b_frame_count", {16'd0, frame_count}, 32'd2);
        rx_model[0] = 8'h9A;
        check_rx();

        // tx buffer lockout while busy
        wr_tx(3'd0, 8'h11);
        rsp_pat[0] = 8'hD1;
        fork
            run_frame(8'h40, 4'd1, 2, 9);
            begin
                repeat (3) @(negedge clk);
                buf_we = 1'b1;
                buf_addr = 3'd0;
                buf_wdata = 8'hAA;
                @(negedge clk);
                buf_we = 1'b0;
            end
        join
        rsp_pat[0] = 8'hD2;
        run_frame(8'h41, 4'd1, 2, 9);

        // table-driven frames
        for (int v = 0; v < 5; v++) begin
            for (int b = 0; b < 8; b++) wr_tx(3'(b), vecs[v].pay[8*b +: 8]);
            for (int b = 0; b < 8; b++) rsp_pat[b] = vecs[v].rsp[8*b +: 8];
            run_frame(vecs[v].cmd, vecs[v].len, vecs[v].nstr, vecs[v].done_t);
        end

        // reset between strobes 2 and 3
        wr_tx(3'd0, 8'h5A);
        wr_tx(3'd1, 8'h6B);
        wr_tx(3'd2, 8'h7C);
        wait_ready();
        req_cmd = 8'h55;
        req_len = 4'd3;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        t = cyc - 1;
        push_frame(t, 8'h55, 3, 17);
        repeat (6) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_strobe", {31'd0, bus_strobe}, 32'd0);
        chk("midrst_bus_data", {24'd0, bus_data}, 32'd0);
        chk("midrst_frame_count", {16'd0, frame_count}, 32'd0);
        chk("midrst_strobes_seen", exp_q.size(), 2);
        exp_q.delete();
        done_q.delete();
        s0 = str_cnt;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        chk("no_strobe_after_reset", str_cnt - s0, 0);
        for (int i = 0; i < 8; i++) begin
            tx_model[i] = 8'h00;
            rx_model[i] = 8'h00;
        end
        fc_model = 0;
        wr_tx(3'd0, 8'h77);
        rsp_pat[0] = 8'h66;
        run_frame(8'h66, 4'd1, 2, 9);

        chk("queue_drain", exp_q.size() + done_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sysctrl_master.md
Name: sysctrl_master

Overview:
- FPGA-side initiator for the system-control byte bus. It drives the strobe, start and data lines and captures the responder's returned byte.
- Local logic queues one command frame at a time: a command byte plus 0..MAX_LEN payload bytes. The block serialises the frame at a fixed strobe spacing and records the response byte after each payload strobe.
- Used for MCU-less bring-up, default-config replay and bench stimulus of system-control responders.

Parameters:
- GAP, 4, clock cycles between consecutive strobes; legal range 2..15. An out-of-range value must cause an elaboration error.
- MAX_LEN, 8, maximum payload bytes per frame; tx and rx buffer depth.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- req_valid  in  1  frame request
- req_ready  out  1  high only in IDLE
- req_cmd  in  8  command byte
- req_len  in  4  payload byte count; values above MAX_LEN are clamped to MAX_LEN
- buf_we  in  1  tx buffer write enable
- buf_addr  in  3  tx buffer write index
- buf_wdata  in  8  tx buffer write data
- rsp_addr  in  3  rx buffer read index
- rsp_data  out  8  rx buffer read data, registered, 1-cycle latency
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse at frame end
- frame_count  out  16  completed frames, wraps at 0xFFFF to 0
- bus_strobe  out  1  byte strobe to responder
- bus_start  out  1  first-byte flag, qualified by bus_strobe
- bus_data  out  8  byte to responder
- bus_din  in  8  responder's returned byte

Behaviour:
- Reset: async, active-high. All outputs go to 0 immediately; state goes to IDLE. req_ready stays 0 while reset is asserted and rises on the first clk edge after release. tx and rx buffers are cleared.
- Any frame in flight at reset is abandoned. No further strobes are issued. The responder resynchronises on the next bus_start.
- States: IDLE, STROBE, GAPWAIT, DONE.
- IDLE:
  - req_ready=1. Acceptance happens at edge T when req_valid && req_ready.
  - At T, the block latches cmd, len_eff = min(req_len, MAX_LEN) and idx=0, and moves to STROBE.
- STROBE (single cycle, T+1 for the command byte):
  - bus_strobe=1.
  - Command byte: bus_start=1, bus_data=cmd.
  - Payload byte k (k=1..len_eff): bus_start=0, bus_data=tx_buf[k-1].
  - Next state is GAPWAIT.
- GAPWAIT:
  - bus_strobe=0, bus_start=0. bus_data holds its last value.
  - A counter runs GAP-1 cycles.
  - On the last GAPWAIT cycle (strobe cycle + GAP-1), if the preceding strobe was payload k, rx_buf[k-1] <= bus_din. The command-byte strobe produces no capture.
  - Then: if payload bytes remain, go to STROBE; else go to DONE.
  - Consequence: consecutive strobes are exactly GAP cycles apart.
- DONE (single cycle, at last strobe + GAP):
  - done=1, busy=0, frame_count+1.
  - Returns to IDLE; req_ready=1 in the following cycle.
  - Earliest next-frame command strobe is 2 cycles after done.
- busy=1 from T+1 through the last GAPWAIT cycle. busy and req_ready are never both 1.
- Total frame duration (acceptance to done) = 1 + (len_eff+1)*GAP cycles.
- Buffer access:
  - buf_we is honoured only in IDLE; writes while busy are dropped.
  - A buf_we at the acceptance edge T is honoured and visible to the frame.
  - buf_addr >= MAX_LEN writes nothing.
  - rx entries at indices >= len_eff keep their previous values.
  - rsp_addr reads at any time; a read while busy may return a partially updated buffer.
- Simultaneous req_valid and reset: reset wins; the request is not accepted.

Test Plan:
- Frame timing and capture: GAP=4, responder model returns 5C/42/04 to status command 0. req_cmd=0, req_len=3, payload 00 00 00, accepted at T -> strobes at T+1, T+5, T+9, T+13; bus_start=1 only at T+1; done at T+17; rx_buf = 5C,42,04; frame_count=1.
- Zero-length frame: req_cmd=1, req_len=0 -> single strobe at T+1 with bus_start=1, bus_data=01; done at T+5; rx_buf unchanged.
- Back-to-back requests: req_valid held high for two frames -> req_ready=0 whenever busy=1; second command strobe occurs exactly done+2; frame_count=2.
- Buffer lockout: buf_we to addr 0 (value AA) during a frame with tx_buf[0]=11 -> payload byte still 11; after done, tx_buf[0]=11 (the busy-time write is dropped).
- Length clamp: req_len=12 -> exactly 9 strobes (1 command + 8 payload); done at T+1+9*GAP.
- Reset mid-frame: assert reset between strobes 2 and 3 -> busy, bus_strobe and bus_data go to 0 without a clk edge; no further strobes; done not pulsed. After release, a new 1-byte frame completes normally.
